// File: rtl/uart_frame_loader.sv
// Framed pixel loader: waits for SYNC_BYTE, writes IMG_SIZE*IMG_SIZE pixel words, aborts on idle timeout.
// Optional trailing checksum byte is enabled by defining FRAME_CHECKSUM_EN.
module uart_frame_loader #(
   parameter  int          DATA_WIDTH   = 16,
   parameter  int          FRAC_BITS    = 7,
   parameter  int          IMG_SIZE     = 28,
   parameter  logic [7:0]  SYNC_BYTE    = 8'hA5,
   parameter  int          TIMEOUT_CLKS = 100000,
   localparam int          N            = IMG_SIZE * IMG_SIZE,
   localparam int          AW           = $clog2(N)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  rx_dv,
   input  logic [7:0]            rx_byte,
   input  logic                  pipe_busy,
   output logic                  pix_we,
   output logic [AW-1:0]         pix_addr,
   output logic [DATA_WIDTH-1:0] pix_data,
   output logic                  frame_loaded,
   output logic                  frame_err,
   output logic                  loading,
   output logic [15:0]           frames_ok
);

   localparam int            TW        = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
   localparam logic [TW-1:0] TIMER_MAX = TW'((TIMEOUT_CLKS > 0) ? TIMEOUT_CLKS - 1 : 0);
   localparam logic [AW-1:0] LAST_PIX  = AW'(N - 1);

`ifdef FRAME_CHECKSUM_EN
   typedef enum logic [1:0] {S_IDLE, S_PIXELS, S_CHECK} state_t;
   logic [7:0] sum_q, sum_d;
`else
   typedef enum logic [1:0] {S_IDLE, S_PIXELS} state_t;
   logic done_pend_q, done_pend_d;
`endif

   state_t                  state_q, state_d;
   logic [AW-1:0]           cnt_q, cnt_d;
   logic [TW-1:0]           timer_q, timer_d;
   logic                    pix_we_d, frame_loaded_d, frame_err_d, loading_d;
   logic [AW-1:0]           pix_addr_d;
   logic [DATA_WIDTH-1:0]   pix_data_d;
   logic [15:0]             frames_ok_d;
   logic                    timeout_hit;

   assign timeout_hit = (TIMEOUT_CLKS != 0) && (timer_q == TIMER_MAX);

   // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      timer_d        = timer_q;
      pix_we_d       = 1'b0;
      pix_addr_d     = pix_addr;
      pix_data_d     = pix_data;
      frame_err_d    = 1'b0;
`ifdef FRAME_CHECKSUM_EN
      sum_d          = sum_q;
      frame_loaded_d = 1'b0;
`else
      done_pend_d    = 1'b0;
      frame_loaded_d = done_pend_q;
`endif
      case (state_q)
         S_IDLE: begin
            timer_d = '0;
            if (rx_dv && rx_byte == SYNC_BYTE && !pipe_busy) begin
               state_d = S_PIXELS;
               cnt_d   = '0;
`ifdef FRAME_CHECKSUM_EN
               sum_d   = '0;
`endif
            end
         end
         S_PIXELS: begin
            if (rx_dv) begin
               timer_d    = '0;
               pix_we_d   = 1'b1;
               pix_addr_d = cnt_q;
               pix_data_d = DATA_WIDTH'(rx_byte) << FRAC_BITS;
`ifdef FRAME_CHECKSUM_EN
               sum_d      = sum_q + rx_byte;
`endif
               if (cnt_q == LAST_PIX) begin
                  cnt_d = '0;
`ifdef FRAME_CHECKSUM_EN
                  state_d = S_CHECK;
`else
                  // loaded pulse lands one cycle after the final write
                  state_d     = S_IDLE;
                  done_pend_d = 1'b1;
`endif
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end else if (timeout_hit) begin
               state_d     = S_IDLE;
               cnt_d       = '0;
               timer_d     = '0;
               frame_err_d = 1'b1;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
`ifdef FRAME_CHECKSUM_EN
         S_CHECK: begin
            if (rx_dv) begin
               state_d = S_IDLE;
               timer_d = '0;
               if (rx_byte == sum_q) frame_loaded_d = 1'b1;
               else                  frame_err_d    = 1'b1;
            end else if (timeout_hit) begin
               state_d     = S_IDLE;
               cnt_d       = '0;
               timer_d     = '0;
               frame_err_d = 1'b1;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase

      frames_ok_d = frames_ok;
      if (frame_loaded_d && frames_ok != 16'hFFFF) frames_ok_d = frames_ok + 16'd1;
      loading_d = (state_d != S_IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         timer_q      <= '0;
         pix_we       <= 1'b0;
         pix_addr     <= '0;
         pix_data     <= '0;
         frame_loaded <= 1'b0;
         frame_err    <= 1'b0;
         loading      <= 1'b0;
         frames_ok    <= '0;
`ifdef FRAME_CHECKSUM_EN
         sum_q        <= '0;
`else
         done_pend_q  <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         timer_q      <= timer_d;
         pix_we       <= pix_we_d;
         pix_addr     <= pix_addr_d;
         pix_data     <= pix_data_d;
         frame_loaded <= frame_loaded_d;
         frame_err    <= frame_err_d;
         loading      <= loading_d;
         frames_ok    <= frames_ok_d;
`ifdef FRAME_CHECKSUM_EN
         sum_q        <= sum_d;
`else
         done_pend_q  <= done_pend_d;
`endif
      end
   end

endmodule
